axi_lite_reg_master: RTL and testbench
======================================

Name: axi_lite_reg_master

Overview:
- Parametrised register-bus to AXI4-Lite master bridge; next generation of the single-width write/read bridge.
- Converts single-cycle local register requests into AXI4-Lite transactions.
- Independent write and read engines; AW and W complete independently; B and R responses are reported back.
- Sits between the control/register sequencer and the AXI4-Lite interconnect of the IP core.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI/register data width; 32 or 64 only.
- REG_ADR_W, 16, local register address width; must be <= ADDR_W.
- ADDR_BASE, 0, base added to the zero-extended local address, truncated to ADDR_W.
- TIMEOUT_CYC, 1024, cycles allowed per transaction before abort (optional feature only).

Ports:
- CLK  in  1  clock
- RST_N  in  1  synchronous active-low reset
- REG_WREN  in  1  write request pulse
- REG_WADR  in  REG_ADR_W  write address
- REG_WDAT  in  DATA_W  write data
- REG_WSTB  in  DATA_W/8  write byte strobes
- REG_WBSY  out  1  write engine busy
- REG_WDONE  out  1  write complete pulse
- REG_WERR  out  2  write status: BRESP, or 2'b11 on timeout
- REG_RDEN  in  1  read request pulse
- REG_RADR  in  REG_ADR_W  read address
- REG_RBSY  out  1  read engine busy
- REG_RDAT  out  DATA_W  read data
- REG_RVLD  out  1  read data valid pulse
- REG_RERR  out  2  read status: RRESP, or 2'b11 on timeout
- S_AXI_AWADDR/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY, S_AXI_ARADDR/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY: AXI4-Lite master, widths ADDR_W / DATA_W / DATA_W/8 / 2.
- AWPROT and ARPROT are not provided; the interconnect ties them to 0.

Behaviour:
- Reset (RST_N=0 at a CLK edge): both FSMs go to IDLE.
- Reset values: all VALID outputs 0, BREADY 0, RREADY 0, REG_WBSY 0, REG_RBSY 0, REG_WDONE 0, REG_RVLD 0, REG_WERR 0, REG_RERR 0, REG_RDAT 0, addresses 0, WDATA 0, WSTRB 0.
- Reset mid-transaction: abandoned silently; no DONE or RVLD pulse is generated.
- Request acceptance:
  - Write accepted when REG_WREN=1 and write FSM is IDLE; read accepted when REG_RDEN=1 and read FSM is IDLE.
  - Requests arriving while busy are ignored. No edge detection: each cycle with WREN high while IDLE is a new request.
- Address: AXADDR = ADDR_BASE + zero-extended local address, mod 2^ADDR_W.
- Write FSM:
  - IDLE -> XFER on accept. Address, data and strobes are registered; AWVALID=WVALID=1 on the next cycle; REG_WBSY=1 from that cycle.
  - XFER: AWVALID drops the cycle after AWREADY&AWVALID; WVALID drops independently after WREADY&WVALID. When both handshakes are done (same cycle or different cycles), go to RESP.
  - RESP: BREADY=1; on BVALID, capture BRESP into REG_WERR, go to DONE.
  - DONE: one cycle with REG_WDONE=1, then IDLE. REG_WBSY clears in the same cycle as REG_WDONE.
- Read FSM:
  - IDLE -> ADDR on accept; ARVALID=1 the cycle after accept.
  - ADDR: hold ARVALID and ARADDR until ARREADY, then go to DATA.
  - DATA: RREADY=1; on RVALID, register RDATA and RRESP; REG_RVLD=1 for one cycle on the following cycle; then IDLE.
  - REG_RDAT holds its value until the next read completes.
- Latency with zero-wait slave: write request to REG_WDONE = 4 cycles; read request to REG_RVLD = 4 cycles.
- Simultaneous read and write: fully independent engines; no ordering between them.
- VALID/address/data signals are stable while VALID=1 and READY=0.
- BRESP or RRESP of SLVERR/DECERR is passed through unchanged; it does not stall the engine.

Optional Feature:
- Macro: AXI_MIF_TIMEOUT_EN
- Defined:
  - A per-engine counter runs in XFER/RESP (write) and ADDR/DATA (read); it resets on FSM entry from IDLE.
  - When the counter reaches TIMEOUT_CYC-1: drop all VALID/READY signals, report REG_WERR or REG_RERR = 2'b11 with the DONE/RVLD pulse, return to IDLE.
  - A response arriving late is ignored.
- Not defined: no counter logic; engines wait indefinitely; code 2'b11 only arises from a DECERR response.

Test Plan:
- Write 0x1234 to address 0x0040, zero-wait slave, ADDR_BASE=0x4000_0000 -> AWADDR=0x4000_0040, WDATA=0x1234, WSTRB=0xF; REG_WDONE exactly 4 cycles after request; REG_WERR=00.
- WREADY 3 cycles before AWREADY, then BVALID delayed 5 cycles -> WVALID drops first, AWVALID held until its handshake, single REG_WDONE pulse; second WREN while busy is ignored (exactly one AW handshake).
- Read address 0x0010, slave returns 0xDEADBEEF with RRESP=10 -> REG_RDAT=0xDEADBEEF, REG_RERR=10, one-cycle REG_RVLD.
- Concurrent write and read in the same cycle -> both AXI channels active simultaneously; both completion pulses occur; data is correct.
- RST_N low while AWVALID=1 -> next cycle all VALIDs 0 and BSY 0; no REG_WDONE pulse.
- With AXI_MIF_TIMEOUT_EN and TIMEOUT_CYC=16, slave never raises ARREADY -> ARVALID drops after 16 cycles; REG_RVLD=1 with REG_RERR=11.

Source files
------------

// File: rtl/axi_lite_reg_master.sv
// Register-bus to AXI4-Lite master bridge with independent write and read engines.
// Optional per-transaction abort timer enabled by defining AXI_MIF_TIMEOUT_EN.
module axi_lite_reg_master #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        REG_ADR_W = 16,
  parameter logic [ADDR_W-1:0]  ADDR_BASE = '0
`ifdef AXI_MIF_TIMEOUT_EN
  , parameter int unsigned      TIMEOUT_CYC = 1024
`endif
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REG_WREN,
  input  logic [REG_ADR_W-1:0] REG_WADR,
  input  logic [DATA_W-1:0]    REG_WDAT,
  input  logic [DATA_W/8-1:0]  REG_WSTB,
  output logic                 REG_WBSY,
  output logic                 REG_WDONE,
  output logic [1:0]           REG_WERR,
  input  logic                 REG_RDEN,
  input  logic [REG_ADR_W-1:0] REG_RADR,
  output logic                 REG_RBSY,
  output logic [DATA_W-1:0]    REG_RDAT,
  output logic                 REG_RVLD,
  output logic [1:0]           REG_RERR,
  output logic [ADDR_W-1:0]    S_AXI_AWADDR,
  output logic                 S_AXI_AWVALID,
  input  logic                 S_AXI_AWREADY,
  output logic [DATA_W-1:0]    S_AXI_WDATA,
  output logic [DATA_W/8-1:0]  S_AXI_WSTRB,
  output logic                 S_AXI_WVALID,
  input  logic                 S_AXI_WREADY,
  input  logic [1:0]           S_AXI_BRESP,
  input  logic                 S_AXI_BVALID,
  output logic                 S_AXI_BREADY,
  output logic [ADDR_W-1:0]    S_AXI_ARADDR,
  output logic                 S_AXI_ARVALID,
  input  logic                 S_AXI_ARREADY,
  input  logic [DATA_W-1:0]    S_AXI_RDATA,
  input  logic [1:0]           S_AXI_RRESP,
  input  logic                 S_AXI_RVALID,
  output logic                 S_AXI_RREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;
`ifdef AXI_MIF_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
`endif

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_DONE} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_e;

  w_state_e            w_state_q, w_state_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                wbsy_q, wbsy_d;
  logic                wdone_q, wdone_d;
  logic [1:0]          werr_q, werr_d;

  r_state_e            r_state_q, r_state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rbsy_q, rbsy_d;
  logic                rvld_q, rvld_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic [1:0]          rerr_q, rerr_d;

`ifdef AXI_MIF_TIMEOUT_EN
  logic [TO_W-1:0]     wcnt_q, wcnt_d;
  logic [TO_W-1:0]     rcnt_q, rcnt_d;
`endif

  // Write engine next-state and registered-output logic
  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    wbsy_d    = wbsy_q;
    wdone_d   = 1'b0;
    werr_d    = werr_q;
`ifdef AXI_MIF_TIMEOUT_EN
    wcnt_d    = '0;
`endif
    unique case (w_state_q)
      W_IDLE: begin
        if (REG_WREN) begin
          w_state_d = W_XFER;
          awaddr_d  = ADDR_BASE + ADDR_W'(REG_WADR);
          wdata_d   = REG_WDAT;
          wstrb_d   = REG_WSTB;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wbsy_d    = 1'b1;
        end
      end
      W_XFER: begin
        if (awvalid_q && S_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && S_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          w_state_d = W_RESP;
          bready_d  = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BVALID) begin
          w_state_d = W_DONE;
          werr_d    = S_AXI_BRESP;
          bready_d  = 1'b0;
          wdone_d   = 1'b1;
          wbsy_d    = 1'b0;
        end
      end
      W_DONE:  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
`ifdef AXI_MIF_TIMEOUT_EN
    // A completed B handshake wins over an expiring timer in the same cycle
    if (w_state_q == W_XFER || w_state_q == W_RESP) begin
      wcnt_d = wcnt_q + TO_W'(1);
      if (w_state_d != W_DONE && wcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        w_state_d = W_DONE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        werr_d    = 2'b11;
        wdone_d   = 1'b1;
        wbsy_d    = 1'b0;
      end
    end
`endif
  end

  // Read engine next-state and registered-output logic
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rbsy_d    = rbsy_q;
    rvld_d    = 1'b0;
    rdat_d    = rdat_q;
    rerr_d    = rerr_q;
`ifdef AXI_MIF_TIMEOUT_EN
    rcnt_d    = '0;
`endif
    unique case (r_state_q)
      R_IDLE: begin
        if (REG_RDEN) begin
          r_state_d = R_ADDR;
          araddr_d  = ADDR_BASE + ADDR_W'(REG_RADR);
          arvalid_d = 1'b1;
          rbsy_d    = 1'b1;
        end
      end
      R_ADDR: begin
        if (S_AXI_ARREADY) begin
          r_state_d = R_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RVALID) begin
          r_state_d = R_DONE;
          rdat_d    = S_AXI_RDATA;
          rerr_d    = S_AXI_RRESP;
          rready_d  = 1'b0;
          rvld_d    = 1'b1;
          rbsy_d    = 1'b0;
        end
      end
      R_DONE:  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
`ifdef AXI_MIF_TIMEOUT_EN
    if (r_state_q == R_ADDR || r_state_q == R_DATA) begin
      rcnt_d = rcnt_q + TO_W'(1);
      if (r_state_d != R_DONE && rcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        r_state_d = R_DONE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        rerr_d    = 2'b11;
        rvld_d    = 1'b1;
        rbsy_d    = 1'b0;
      end
    end
`endif
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wbsy_q    <= 1'b0;
      wdone_q   <= 1'b0;
      werr_q    <= '0;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rbsy_q    <= 1'b0;
      rvld_q    <= 1'b0;
      rdat_q    <= '0;
      rerr_q    <= '0;
`ifdef AXI_MIF_TIMEOUT_EN
      wcnt_q    <= '0;
      rcnt_q    <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      wbsy_q    <= wbsy_d;
      wdone_q   <= wdone_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rbsy_q    <= rbsy_d;
      rvld_q    <= rvld_d;
      rdat_q    <= rdat_d;
      rerr_q    <= rerr_d;
`ifdef AXI_MIF_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
`endif
    end
  end

  assign S_AXI_AWADDR  = awaddr_q;
  assign S_AXI_AWVALID = awvalid_q;
  assign S_AXI_WDATA   = wdata_q;
  assign S_AXI_WSTRB   = wstrb_q;
  assign S_AXI_WVALID  = wvalid_q;
  assign S_AXI_BREADY  = bready_q;
  assign S_AXI_ARADDR  = araddr_q;
  assign S_AXI_ARVALID = arvalid_q;
  assign S_AXI_RREADY  = rready_q;
  assign REG_WBSY      = wbsy_q;
  assign REG_WDONE     = wdone_q;
  assign REG_WERR      = werr_q;
  assign REG_RBSY      = rbsy_q;
  assign REG_RVLD      = rvld_q;
  assign REG_RDAT      = rdat_q;
  assign REG_RERR      = rerr_q;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Scoreboard bench for axi_lite_reg_master with a configurable-latency AXI4-Lite slave model.
module tb_axi_lite_reg_master;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_ADR_W = 16;
  localparam logic [31:0] BASE      = 32'h4000_0000;

  logic        CLK, RST_N;
  logic        REG_WREN, REG_WBSY, REG_WDONE;
  logic [15:0] REG_WADR;
  logic [31:0] REG_WDAT;
  logic [3:0]  REG_WSTB;
  logic [1:0]  REG_WERR;
  logic        REG_RDEN, REG_RBSY, REG_RVLD;
  logic [15:0] REG_RADR;
  logic [31:0] REG_RDAT;
  logic [1:0]  REG_RERR;

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  // Slave model knobs and state
  int unsigned aw_delay, w_delay, b_delay, ar_delay, r_delay;
  bit          ar_never;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          got_aw, got_w, r_pend;

  // Scoreboard queues
  logic [31:0] exp_aw[$], act_aw[$], exp_ar[$], act_ar[$];
  logic [35:0] exp_w[$], act_w[$];
  logic [1:0]  exp_werr[$];
  logic [33:0] exp_rd[$];

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_reg_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_ADR_W(REG_ADR_W), .ADDR_BASE(BASE)
`ifdef AXI_MIF_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REG_WREN(REG_WREN), .REG_WADR(REG_WADR), .REG_WDAT(REG_WDAT), .REG_WSTB(REG_WSTB),
    .REG_WBSY(REG_WBSY), .REG_WDONE(REG_WDONE), .REG_WERR(REG_WERR),
    .REG_RDEN(REG_RDEN), .REG_RADR(REG_RADR), .REG_RBSY(REG_RBSY),
    .REG_RDAT(REG_RDAT), .REG_RVLD(REG_RVLD), .REG_RERR(REG_RERR),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid && !ar_never && (ar_cnt >= ar_delay);

  wire aw_hs = awvalid && awready;
  wire w_hs  = wvalid && wready;
  wire ar_hs = arvalid && arready;

  // Slave: ready after N waiting cycles, response N cycles after the request completes
  always @(posedge CLK) begin
    if (!RST_N) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      if (aw_hs) begin aw_cnt <= 0; got_aw <= 1'b1; act_aw.push_back(awaddr); end
      if (wvalid && !wready) w_cnt <= w_cnt + 1;
      if (w_hs) begin w_cnt <= 0; got_w <= 1'b1; act_w.push_back({wstrb, wdata}); end
      if (bvalid && bready) bvalid <= 1'b0;
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        if (b_cnt == b_delay) begin
          bvalid <= 1'b1; bresp <= bresp_cfg; got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
      if (ar_hs) begin ar_cnt <= 0; r_pend <= 1'b1; act_ar.push_back(araddr); end
      if (rvalid && rready) rvalid <= 1'b0;
      if (r_pend || ar_hs) begin
        if (r_cnt == r_delay) begin
          rvalid <= 1'b1; rdata <= rdata_cfg; rresp <= rresp_cfg; r_pend <= 1'b0; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  task automatic slave_cfg(input int unsigned awd, input int unsigned wd, input int unsigned bd,
                           input logic [1:0] br, input int unsigned ard, input int unsigned rd,
                           input logic [31:0] rdat, input logic [1:0] rr);
    aw_delay = awd; w_delay = wd; b_delay = bd; bresp_cfg = br;
    ar_delay = ard; r_delay = rd; rdata_cfg = rdat; rresp_cfg = rr; ar_never = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REG_WREN = 1'b0; REG_RDEN = 1'b0;
    REG_WADR = '0; REG_WDAT = '0; REG_WSTB = '0; REG_RADR = '0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_axi_ctrl: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    n_checks++;
    if ({REG_WBSY, REG_WDONE, REG_RBSY, REG_RVLD, REG_WERR, REG_RERR} !== 8'h00) begin
      n_fail++; $display("FAIL reset_reg_status: got %b expected 00000000",
                         {REG_WBSY, REG_WDONE, REG_RBSY, REG_RVLD, REG_WERR, REG_RERR});
    end
    n_checks++;
    if ({awaddr, araddr, wdata, wstrb, REG_RDAT} !== 132'h0) begin
      n_fail++; $display("FAIL reset_data: awaddr %h araddr %h wdata %h wstrb %h rdat %h expected all 0",
                         awaddr, araddr, wdata, wstrb, REG_RDAT);
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_write_basic();
    int cyc;
    logic [31:0] ga;
    logic [35:0] gw;
    slave_cfg(0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00);
    REG_WREN = 1'b1; REG_WADR = 16'h0040; REG_WDAT = 32'h0000_1234; REG_WSTB = 4'hF;
    exp_aw.push_back(32'h4000_0040); exp_w.push_back({4'hF, 32'h0000_1234}); exp_werr.push_back(2'b00);
    cyc = 1;
    @(negedge CLK); REG_WREN = 1'b0; cyc++;
    n_checks++;
    if ({awvalid, wvalid, REG_WBSY} !== 3'b111) begin
      n_fail++; $display("FAIL wr_basic_valid: got %b expected 111", {awvalid, wvalid, REG_WBSY});
    end
    for (int i = 0; i < 20; i++) begin
      if (REG_WDONE) break;
      @(negedge CLK); cyc++;
    end
    n_checks++;
    if (REG_WDONE !== 1'b1 || cyc != 4) begin
      n_fail++; $display("FAIL wr_basic_latency: wdone %b in cycle %0d expected 1 in cycle 4", REG_WDONE, cyc);
    end
    n_checks++;
    if ({REG_WERR, REG_WBSY} !== {exp_werr.pop_front(), 1'b0}) begin
      n_fail++; $display("FAIL wr_basic_status: werr %b wbsy %b expected 00 0", REG_WERR, REG_WBSY);
    end
    if (act_aw.size() != 0) ga = act_aw.pop_front(); else ga = 'x;
    if (act_w.size() != 0) gw = act_w.pop_front(); else gw = 'x;
    n_checks++;
    if (ga !== exp_aw[0]) begin
      n_fail++; $display("FAIL wr_basic_awaddr: got %h expected %h", ga, exp_aw[0]);
    end
    n_checks++;
    if (gw !== exp_w[0]) begin
      n_fail++; $display("FAIL wr_basic_wdata: got %h expected %h", gw, exp_w[0]);
    end
    void'(exp_aw.pop_front()); void'(exp_w.pop_front());
    @(negedge CLK);
    n_checks++;
    if (REG_WDONE !== 1'b0) begin
      n_fail++; $display("FAIL wr_basic_pulse: wdone %b expected 0", REG_WDONE);
    end
  endtask

  task automatic test_write_skew();
    int pulses, n_aw;
    bit stable_ok;
    logic [1:0] werr_seen;
    logic [31:0] ga;
    logic [35:0] gw;
    slave_cfg(3, 0, 5, 2'b10, 0, 0, 32'h0, 2'b00);
    REG_WREN = 1'b1; REG_WADR = 16'h0100; REG_WDAT = 32'hA5A5_0001; REG_WSTB = 4'h3;
    exp_aw.push_back(32'h4000_0100); exp_w.push_back({4'h3, 32'hA5A5_0001}); exp_werr.push_back(2'b10);
    @(negedge CLK); REG_WREN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({awvalid, wvalid} !== 2'b10) begin
      n_fail++; $display("FAIL wr_skew_w_first: awvalid,wvalid %b expected 10", {awvalid, wvalid});
    end
    REG_WREN = 1'b1; REG_WADR = 16'h0200; REG_WDAT = 32'hFFFF_FFFF; REG_WSTB = 4'hF;
    pulses = 0; stable_ok = 1'b1; werr_seen = 'x;
    for (int i = 0; i < 30; i++) begin
      if (awvalid && awaddr !== exp_aw[0]) stable_ok = 1'b0;
      if (REG_WDONE) begin pulses++; werr_seen = REG_WERR; end
      @(negedge CLK); REG_WREN = 1'b0;
    end
    n_aw = act_aw.size();
    n_checks++;
    if (pulses != 1 || n_aw != 1) begin
      n_fail++; $display("FAIL wr_skew_count: wdone pulses %0d aw handshakes %0d expected 1 1", pulses, n_aw);
    end
    n_checks++;
    if (werr_seen !== exp_werr.pop_front()) begin
      n_fail++; $display("FAIL wr_skew_bresp: got %b expected 10", werr_seen);
    end
    n_checks++;
    if (!stable_ok) begin
      n_fail++; $display("FAIL wr_skew_stable: awaddr changed while awvalid, got %h expected %h", awaddr, exp_aw[0]);
    end
    if (act_aw.size() != 0) ga = act_aw.pop_front(); else ga = 'x;
    if (act_w.size() != 0) gw = act_w.pop_front(); else gw = 'x;
    n_checks++;
    if ({ga, gw} !== {exp_aw.pop_front(), exp_w.pop_front()}) begin
      n_fail++; $display("FAIL wr_skew_payload: got %h %h expected 40000100 3a5a50001", ga, gw);
    end
    act_aw.delete(); act_w.delete();
  endtask

  task automatic test_read();
    int cyc;
    logic [31:0] ga;
    slave_cfg(0, 0, 0, 2'b00, 0, 0, 32'hDEAD_BEEF, 2'b10);
    REG_RDEN = 1'b1; REG_RADR = 16'h0010;
    exp_ar.push_back(32'h4000_0010); exp_rd.push_back({2'b10, 32'hDEAD_BEEF});
    cyc = 1;
    @(negedge CLK); REG_RDEN = 1'b0; cyc++;
    for (int i = 0; i < 20; i++) begin
      if (REG_RVLD) break;
      @(negedge CLK); cyc++;
    end
    n_checks++;
    if (REG_RVLD !== 1'b1 || cyc != 4) begin
      n_fail++; $display("FAIL rd_latency: rvld %b in cycle %0d expected 1 in cycle 4", REG_RVLD, cyc);
    end
    n_checks++;
    if ({REG_RERR, REG_RDAT} !== exp_rd[0]) begin
      n_fail++; $display("FAIL rd_data: got %b %h expected %b %h", REG_RERR, REG_RDAT, exp_rd[0][33:32], exp_rd[0][31:0]);
    end
    @(negedge CLK);
    n_checks++;
    if (REG_RVLD !== 1'b0 || REG_RDAT !== exp_rd[0][31:0]) begin
      n_fail++; $display("FAIL rd_hold: rvld %b rdat %h expected 0 deadbeef", REG_RVLD, REG_RDAT);
    end
    void'(exp_rd.pop_front());
    // Top local address, two-cycle data latency; previous data must stay visible
    slave_cfg(0, 0, 0, 2'b00, 1, 2, 32'h0BAD_F00D, 2'b00);
    REG_RDEN = 1'b1; REG_RADR = 16'hFFFF;
    exp_ar.push_back(32'h4000_FFFF); exp_rd.push_back({2'b00, 32'h0BAD_F00D});
    @(negedge CLK); REG_RDEN = 1'b0;
    n_checks++;
    if (REG_RDAT !== 32'hDEAD_BEEF || REG_RBSY !== 1'b1) begin
      n_fail++; $display("FAIL rd_busy_hold: rdat %h rbsy %b expected deadbeef 1", REG_RDAT, REG_RBSY);
    end
    for (int i = 0; i < 20; i++) begin
      if (REG_RVLD) break;
      @(negedge CLK);
    end
    n_checks++;
    if ({REG_RVLD, REG_RERR, REG_RDAT} !== {1'b1, exp_rd.pop_front()}) begin
      n_fail++; $display("FAIL rd_top_addr: rvld %b rerr %b rdat %h expected 1 00 0badf00d", REG_RVLD, REG_RERR, REG_RDAT);
    end
    for (int k = 0; k < 2; k++) begin
      if (act_ar.size() != 0) ga = act_ar.pop_front(); else ga = 'x;
      n_checks++;
      if (ga !== exp_ar[0]) begin
        n_fail++; $display("FAIL rd_araddr_%0d: got %h expected %h", k, ga, exp_ar[0]);
      end
      void'(exp_ar.pop_front());
    end
    @(negedge CLK);
  endtask

  task automatic test_concurrent();
    bit w_seen, r_seen;
    logic [1:0]  werr_seen;
    logic [33:0] rd_seen;
    logic [31:0] ga, gr;
    logic [35:0] gw;
    slave_cfg(0, 1, 1, 2'b00, 0, 0, 32'h1357_9BDF, 2'b00);
    REG_WREN = 1'b1; REG_WADR = 16'h0008; REG_WDAT = 32'h5555_AAAA; REG_WSTB = 4'hF;
    REG_RDEN = 1'b1; REG_RADR = 16'h000C;
    exp_aw.push_back(32'h4000_0008); exp_w.push_back({4'hF, 32'h5555_AAAA}); exp_werr.push_back(2'b00);
    exp_ar.push_back(32'h4000_000C); exp_rd.push_back({2'b00, 32'h1357_9BDF});
    @(negedge CLK); REG_WREN = 1'b0; REG_RDEN = 1'b0;
    n_checks++;
    if ({awvalid, wvalid, arvalid} !== 3'b111) begin
      n_fail++; $display("FAIL conc_channels: aw,w,ar valid %b expected 111", {awvalid, wvalid, arvalid});
    end
    w_seen = 1'b0; r_seen = 1'b0; werr_seen = 'x; rd_seen = 'x;
    for (int i = 0; i < 20; i++) begin
      if (REG_WDONE) begin w_seen = 1'b1; werr_seen = REG_WERR; end
      if (REG_RVLD)  begin r_seen = 1'b1; rd_seen = {REG_RERR, REG_RDAT}; end
      @(negedge CLK);
    end
    n_checks++;
    if ({w_seen, r_seen} !== 2'b11 || werr_seen !== exp_werr.pop_front()) begin
      n_fail++; $display("FAIL conc_done: wdone %b rvld %b werr %b expected 1 1 00", w_seen, r_seen, werr_seen);
    end
    n_checks++;
    if (rd_seen !== exp_rd.pop_front()) begin
      n_fail++; $display("FAIL conc_rdata: got %h expected 013579bdf", rd_seen);
    end
    if (act_aw.size() != 0) ga = act_aw.pop_front(); else ga = 'x;
    if (act_w.size() != 0) gw = act_w.pop_front(); else gw = 'x;
    if (act_ar.size() != 0) gr = act_ar.pop_front(); else gr = 'x;
    n_checks++;
    if ({ga, gw, gr} !== {exp_aw.pop_front(), exp_w.pop_front(), exp_ar.pop_front()}) begin
      n_fail++; $display("FAIL conc_payload: aw %h w %h ar %h expected 40000008 f5555aaaa 4000000c", ga, gw, gr);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    slave_cfg(10, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00);
    REG_WREN = 1'b1; REG_WADR = 16'h0080; REG_WDAT = 32'h0000_0077; REG_WSTB = 4'h1;
    @(negedge CLK); REG_WREN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (awvalid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: awvalid %b expected 1", awvalid);
    end
    RST_N = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, REG_WBSY, REG_RBSY, REG_WDONE} !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_clear: got %b expected 00000000",
                         {awvalid, wvalid, bready, arvalid, rready, REG_WBSY, REG_RBSY, REG_WDONE});
    end
    RST_N = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (REG_WDONE) pulses++;
    end
    n_checks++;
    if (pulses != 0 || act_aw.size() != 0) begin
      n_fail++; $display("FAIL rst_mid_silent: wdone pulses %0d aw handshakes %0d expected 0 0", pulses, act_aw.size());
    end
    act_aw.delete(); act_w.delete();
  endtask

`ifdef AXI_MIF_TIMEOUT_EN
  task automatic test_timeout();
    int arv_cycles;
    slave_cfg(0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00);
    ar_never = 1'b1;
    REG_RDEN = 1'b1; REG_RADR = 16'h0020;
    @(negedge CLK); REG_RDEN = 1'b0;
    arv_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (REG_RVLD) break;
      if (arvalid) arv_cycles++;
      @(negedge CLK);
    end
    n_checks++;
    if (arv_cycles != 16) begin
      n_fail++; $display("FAIL to_arvalid_len: arvalid held %0d cycles expected 16", arv_cycles);
    end
    n_checks++;
    if ({REG_RVLD, REG_RERR, arvalid} !== 4'b1110) begin
      n_fail++; $display("FAIL to_status: rvld %b rerr %b arvalid %b expected 1 11 0", REG_RVLD, REG_RERR, arvalid);
    end
    ar_never = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({REG_RVLD, REG_RBSY, arvalid, act_ar.size() == 0} !== 4'b0001) begin
      n_fail++; $display("FAIL to_idle: rvld %b rbsy %b arvalid %b ar handshakes %0d expected 0 0 0 0",
                         REG_RVLD, REG_RBSY, arvalid, act_ar.size());
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    slave_cfg(0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00);
    test_reset();
    test_write_basic();
    test_write_skew();
    test_read();
    test_concurrent();
    test_reset_mid();
`ifdef AXI_MIF_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
